// File: rtl/tone_mixer_pkg.sv
// Shared definitions for the tone_mixer sample path.
//   - Mixer FSM state encoding (IDLE, CAPTURE, ACCUM, WRITE).
//   - Accumulator guard bits: ACC_W = SAMPLE_W + ACC_GUARD. Four guard bits cover
//     up to 8 voices plus pass-through without wrapping before saturation.
//   - Helper for index-counter width.
package tone_mixer_pkg;

    localparam int unsigned ACC_GUARD = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_ACCUM   = 2'd2,
        ST_WRITE   = 2'd3
    } mix_state_t;

    // Width of a counter that indexes n items; at least one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tone_mixer_voice.sv
// tone_voice: one free-running square-wave tone generator.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   en           voice enable; when low the counter and phase are held at 0
//   half_period  half-period in clock cycles; 0 silences the voice
//   amp          unsigned amplitude
//   contrib_c    signed contribution (+amp in phase 0, -amp in phase 1), combinational
module tone_voice #(
    parameter int unsigned DIV_W = 19,
    parameter int unsigned AMP_W = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [DIV_W-1:0]        half_period,
    input  logic [AMP_W-1:0]        amp,
    output logic signed [AMP_W:0]   contrib_c
);

    logic [DIV_W-1:0]       count;
    logic                   phase;
    logic                   active;
    logic signed [AMP_W:0]  amp_s;

    assign active = en && (half_period != '0);
    assign amp_s  = signed'({1'b0, amp});

    // Half-period counter; '>=' lets a shrunk period wrap on the very next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            phase <= 1'b0;
        end else if (!active) begin
            count <= '0;
            phase <= 1'b0;
        end else if (count >= (half_period - DIV_W'(1))) begin
            count <= '0;
            phase <= ~phase;
        end else begin
            count <= count + DIV_W'(1);
        end
    end

    assign contrib_c = !active ? '0 : (phase ? -amp_s : amp_s);

endmodule

// File: rtl/tone_mixer.sv
// tone_mixer: multi-voice square-wave synthesiser and mixer for the audio controller.
// Ports:
//   CLOCK_50, resetn            clock, async active-low reset
//   voice_en                    per-voice enable
//   voice_half_period           packed half-periods, voice i at [i*DIV_W +: DIV_W]
//   voice_amp                   packed amplitudes,   voice i at [i*AMP_W +: AMP_W]
//   passthru_en                 add mic input into the mix (sampled at capture)
//   audio_in_available          controller has an input sample
//   audio_out_allowed           controller output FIFO has space
//   left/right_channel_audio_in mic samples, signed
//   read_audio_in               one-cycle pop of the input sample
//   write_audio_out             one-cycle push of the output sample
//   left/right_channel_audio_out saturated mix, signed, registered
module tone_mixer
    import tone_mixer_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned SAMPLE_W   = 32,
    parameter int unsigned DIV_W      = 19,
    parameter int unsigned AMP_W      = 24
) (
    input  logic                            CLOCK_50,
    input  logic                            resetn,
    input  logic [NUM_VOICES-1:0]           voice_en,
    input  logic [NUM_VOICES*DIV_W-1:0]     voice_half_period,
    input  logic [NUM_VOICES*AMP_W-1:0]     voice_amp,
    input  logic                            passthru_en,
    input  logic                            audio_in_available,
    input  logic                            audio_out_allowed,
    input  logic signed [SAMPLE_W-1:0]      left_channel_audio_in,
    input  logic signed [SAMPLE_W-1:0]      right_channel_audio_in,
    output logic                            read_audio_in,
    output logic                            write_audio_out,
    output logic signed [SAMPLE_W-1:0]      left_channel_audio_out,
    output logic signed [SAMPLE_W-1:0]      right_channel_audio_out
);

    localparam int unsigned ACC_W = SAMPLE_W + ACC_GUARD;
    localparam int unsigned IDX_W = idx_width(NUM_VOICES);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    mix_state_t                 state;
    logic [IDX_W-1:0]           voice_idx;
    logic signed [AMP_W:0]      voice_contrib_c [NUM_VOICES];
    logic signed [AMP_W:0]      snap [NUM_VOICES];
    logic signed [ACC_W-1:0]    acc_l;
    logic signed [ACC_W-1:0]    acc_r;
    logic signed [ACC_W-1:0]    addend_c;
    logic signed [ACC_W-1:0]    acc_l_next_c;
    logic signed [ACC_W-1:0]    acc_r_next_c;

    // Clamp to the signed sample range instead of wrapping.
    function automatic logic signed [SAMPLE_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[SAMPLE_W-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[SAMPLE_W-1:0];
        end else begin
            return v[SAMPLE_W-1:0];
        end
    endfunction

    // Tone generators run continuously, independent of the sample handshake.
    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        tone_voice #(
            .DIV_W (DIV_W),
            .AMP_W (AMP_W)
        ) u_voice (
            .clk         (CLOCK_50),
            .rst_n       (resetn),
            .en          (voice_en[i]),
            .half_period (voice_half_period[i*DIV_W +: DIV_W]),
            .amp         (voice_amp[i*AMP_W +: AMP_W]),
            .contrib_c   (voice_contrib_c[i])
        );
    end

    // One snapshotted voice is added per ACCUM cycle.
    assign addend_c     = ACC_W'(snap[voice_idx]);
    assign acc_l_next_c = acc_l + addend_c;
    assign acc_r_next_c = acc_r + addend_c;

    // Sample sequencer: capture -> accumulate voices -> write once.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state                   <= ST_IDLE;
            voice_idx               <= '0;
            acc_l                   <= '0;
            acc_r                   <= '0;
            read_audio_in           <= 1'b0;
            write_audio_out         <= 1'b0;
            left_channel_audio_out  <= '0;
            right_channel_audio_out <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                snap[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (audio_in_available && audio_out_allowed) begin
                        state         <= ST_CAPTURE;
                        read_audio_in <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    // The sample is popped even when pass-through is off.
                    read_audio_in <= 1'b0;
                    acc_l         <= passthru_en ? ACC_W'(left_channel_audio_in)  : '0;
                    acc_r         <= passthru_en ? ACC_W'(right_channel_audio_in) : '0;
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        snap[i] <= voice_contrib_c[i];
                    end
                    voice_idx <= '0;
                    state     <= ST_ACCUM;
                end
                ST_ACCUM: begin
                    acc_l     <= acc_l_next_c;
                    acc_r     <= acc_r_next_c;
                    voice_idx <= voice_idx + IDX_W'(1);
                    if (voice_idx == IDX_W'(NUM_VOICES - 1)) begin
                        // Final sum goes straight to the output regs so the
                        // write can fire on the first WRITE cycle.
                        left_channel_audio_out  <= saturate(acc_l_next_c);
                        right_channel_audio_out <= saturate(acc_r_next_c);
                        write_audio_out         <= audio_out_allowed;
                        state                   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (write_audio_out) begin
                        write_audio_out <= 1'b0;
                        state           <= ST_IDLE;
                    end else if (audio_out_allowed) begin
                        write_audio_out <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_mixer.sv
// Self-checking bench for tone_mixer: directed steps plus a randomized run,
// every written sample compared against a behavioural mix model.
module tb_tone_mixer;

    localparam int N  = 4;
    localparam int SW = 32;
    localparam int DW = 19;
    localparam int AW = 24;

    logic                   clk;
    logic                   resetn;
    logic [N-1:0]           voice_en;
    logic [N*DW-1:0]        voice_half_period;
    logic [N*AW-1:0]        voice_amp;
    logic                   passthru_en;
    logic                   avail;
    logic                   allowed;
    logic signed [SW-1:0]   lin;
    logic signed [SW-1:0]   rin;
    logic                   rd;
    logic                   wr;
    logic signed [SW-1:0]   lout;
    logic signed [SW-1:0]   rout;

    int tests = 0;
    int fails = 0;

    tone_mixer #(
        .NUM_VOICES (N),
        .SAMPLE_W   (SW),
        .DIV_W      (DW),
        .AMP_W      (AW)
    ) dut (
        .CLOCK_50                (clk),
        .resetn                  (resetn),
        .voice_en                (voice_en),
        .voice_half_period       (voice_half_period),
        .voice_amp               (voice_amp),
        .passthru_en             (passthru_en),
        .audio_in_available      (avail),
        .audio_out_allowed       (allowed),
        .left_channel_audio_in   (lin),
        .right_channel_audio_in  (rin),
        .read_audio_in           (rd),
        .write_audio_out         (wr),
        .left_channel_audio_out  (lout),
        .right_channel_audio_out (rout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  m_cnt [N];
    bit  m_ph  [N];

    // Tone rule: count up, wrap and flip phase once count reaches half_period-1.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N; i++) begin
                m_cnt[i] <= 0;
                m_ph[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                automatic int hp = int'(voice_half_period[i*DW +: DW]);
                if (!voice_en[i] || hp == 0) begin
                    m_cnt[i] <= 0;
                    m_ph[i]  <= 1'b0;
                end else if (m_cnt[i] >= hp - 1) begin
                    m_cnt[i] <= 0;
                    m_ph[i]  <= ~m_ph[i];
                end else begin
                    m_cnt[i] <= m_cnt[i] + 1;
                end
            end
        end
    end

    function automatic longint model_mix(input longint pass);
        longint s;
        longint a;
        s = pass;
        for (int i = 0; i < N; i++) begin
            if (voice_en[i] && voice_half_period[i*DW +: DW] != '0) begin
                a = longint'({40'd0, voice_amp[i*AW +: AW]});
                s = m_ph[i] ? s - a : s + a;
            end
        end
        if (s > 64'sd2147483647)  s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
        return s;
    endfunction

    longint exp_l [$];
    longint exp_r [$];
    int     n_writes  = 0;
    longint last_l    = 0;
    longint last_r    = 0;
    int     cnt_pos   = 0;
    int     cnt_neg   = 0;
    int     cnt_other = 0;

    // Monitor: predict at the pop, compare at the push.
    always @(negedge clk) begin
        if (resetn) begin
            if (rd || wr) check("rw_exclusive", longint'(rd && wr), 0);
            if (rd) begin
                exp_l.push_back(model_mix(passthru_en ? longint'(lin) : 0));
                exp_r.push_back(model_mix(passthru_en ? longint'(rin) : 0));
            end
            if (wr) begin
                if (exp_l.size() == 0) begin
                    check("write_unexpected", 1, 0);
                end else begin
                    check("mix_left",  longint'(lout), exp_l.pop_front());
                    check("mix_right", longint'(rout), exp_r.pop_front());
                end
                last_l = longint'(lout);
                last_r = longint'(rout);
                if (last_l == 1000) cnt_pos++;
                else if (last_l == -1000) cnt_neg++;
                else cnt_other++;
                n_writes++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        resetn = 1'b0;
        avail  = 1'b0;
        exp_l.delete();
        exp_r.delete();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic set_voice(input int i, input bit en, input int hp, input int amp);
        voice_en[i] = en;
        voice_half_period[i*DW +: DW] = DW'(hp);
        voice_amp[i*AW +: AW] = AW'(amp);
    endtask

    task automatic do_txn();
        int  w0;
        int  k;
        bit  got;
        w0 = n_writes;
        @(posedge clk); #1;
        avail = 1'b1;
        allowed = 1'b1;
        got = 1'b0;
        k = 0;
        while (!got && k < 10) begin
            @(negedge clk);
            got = rd;
            k++;
        end
        @(posedge clk); #1;
        avail = 1'b0;
        check("txn_read", longint'(got), 1);
        k = 0;
        while (n_writes == w0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("txn_write", longint'(n_writes != w0), 1);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int     w0;
        int     rd_k;
        int     wr_k;
        int     hw;
        int     unst;
        int     wa;
        int     wk;
        longint hold_l;
        longint hold_r;
        longint wl;
        bit     got;

        resetn = 1'b0;
        voice_en = '0;
        voice_half_period = '0;
        voice_amp = '0;
        passthru_en = 1'b0;
        avail = 1'b0;
        allowed = 1'b0;
        lin = '0;
        rin = '0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("reset_read",  longint'(rd), 0);
        check("reset_write", longint'(wr), 0);
        check("reset_left",  longint'(lout), 0);
        check("reset_right", longint'(rout), 0);

        // Reset mid-ACCUM
        set_voice(0, 1, 200000, 1000);
        do_reset();
        do_txn();
        check("pre_reset_left", last_l, 1000);
        @(posedge clk); #1;
        avail = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            got = rd;
        end
        @(posedge clk); #1;
        avail = 1'b0;
        #1 resetn = 1'b0;
        exp_l.delete();
        exp_r.delete();
        #1;
        check("midreset_left",  longint'(lout), 0);
        check("midreset_right", longint'(rout), 0);
        check("midreset_write", longint'(wr), 0);
        check("midreset_read",  longint'(rd), 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        w0 = n_writes;
        repeat (12) @(negedge clk);
        check("no_write_after_reset", n_writes - w0, 0);

        // Single tone, back-to-back samples
        set_voice(0, 1, 5, 1000);
        passthru_en = 1'b0;
        do_reset();
        cnt_pos = 0; cnt_neg = 0; cnt_other = 0;
        w0 = n_writes;
        @(posedge clk); #1;
        avail = 1'b1; allowed = 1'b1;
        repeat (100) @(posedge clk);
        #1 avail = 1'b0;
        repeat (15) @(posedge clk);
        check("tone_other_values", cnt_other, 0);
        check("tone_saw_pos", longint'(cnt_pos > 0), 1);
        check("tone_saw_neg", longint'(cnt_neg > 0), 1);
        check("tone_sample_count", longint'(n_writes - w0 >= 10), 1);

        // Handshake latency and WRITE hold
        set_voice(0, 1, 1000, 100);
        set_voice(1, 1, 1001, 200);
        set_voice(2, 1, 1002, 300);
        set_voice(3, 1, 1003, 400);
        passthru_en = 1'b1; lin = 50; rin = -50;
        do_reset();
        @(posedge clk); #1;
        avail = 1'b1; allowed = 1'b1;
        rd_k = -1; wr_k = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rd && rd_k < 0) rd_k = k;
            if (wr && wr_k < 0) wr_k = k;
            @(posedge clk); #1;
            if (rd_k >= 0) avail = 1'b0;
        end
        check("latency_read", rd_k, 1);
        check("latency_write", wr_k, 6);

        repeat (3) @(posedge clk);
        #1 avail = 1'b1; allowed = 1'b1;
        hw = 0; unst = 0; wa = 0; wk = -1; wl = 0; hold_l = 0; hold_r = 0;
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            if (k == 1) check("hold_read", longint'(rd), 1);
            if (k == 6) begin
                hold_l = longint'(lout);
                hold_r = longint'(rout);
            end
            if (k >= 6 && k <= 15) begin
                if (wr) hw++;
                if (longint'(lout) != hold_l || longint'(rout) != hold_r) unst++;
            end
            if (k >= 16 && wr) begin
                wa++; wk = k; wl = longint'(lout);
            end
            @(posedge clk); #1;
            if (k == 1) begin avail = 1'b0; allowed = 1'b0; end
            if (k == 15) allowed = 1'b1;
        end
        check("hold_no_write", hw, 0);
        check("hold_stable", unst, 0);
        check("hold_one_write", wa, 1);
        check("hold_write_cycle", wk, 17);
        check("hold_write_value", wl, hold_l);
        check("hold_value", hold_l, 1050);

        // Saturation
        voice_en = '0;
        set_voice(0, 1, 200000, 'h0FFFFF);
        passthru_en = 1'b1; lin = 32'sh7FFFFF00; rin = 32'sh7FFFFF00;
        do_reset();
        do_txn();
        check("sat_pos_left",  last_l, 64'sd2147483647);
        check("sat_pos_right", last_r, 64'sd2147483647);
        set_voice(0, 1, 20, 'h0FFFFF);
        lin = -32'sh7FFFFF00; rin = -32'sh7FFFFF00;
        do_reset();
        repeat (21) @(posedge clk);
        do_txn();
        check("sat_neg_left",  last_l, -64'sd2147483648);
        check("sat_neg_right", last_r, -64'sd2147483648);

        // Four-voice mix
        set_voice(0, 1, 1000, 100);
        set_voice(1, 1, 1001, 200);
        set_voice(2, 1, 1002, 300);
        set_voice(3, 1, 1003, 400);
        passthru_en = 1'b1; lin = 50; rin = 50;
        do_reset();
        do_txn();
        check("mix_all", last_l, 1050);
        voice_en[2] = 1'b0;
        do_txn();
        check("mix_no_v2", last_l, 750);

        // Period shrink: count 12 of 20, then half-period 5
        voice_en = '0;
        set_voice(0, 1, 20, 1000);
        passthru_en = 1'b0;
        do_reset();
        repeat (12) @(posedge clk);
        #1 voice_half_period[0 +: DW] = DW'(5);
        repeat (2) @(posedge clk);
        #1 avail = 1'b1; allowed = 1'b1;
        @(posedge clk);
        #1 avail = 1'b0;
        repeat (13) @(posedge clk);
        check("shrink_first", last_l, -1000);
        #1 avail = 1'b1;
        @(posedge clk);
        #1 avail = 1'b0;
        repeat (10) @(posedge clk);
        check("shrink_second", last_l, 1000);

        // Randomized traffic with mid-sample parameter changes and stalls
        do_reset();
        for (int c = 0; c < 900; c++) begin
            @(posedge clk); #1;
            avail = 1'($urandom_range(0, 1));
            allowed = ($urandom_range(0, 3) != 0);
            lin = $urandom;
            rin = $urandom;
            passthru_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < N; i++) begin
                    set_voice(i, ($urandom_range(0, 3) != 0), $urandom_range(0, 40),
                              int'($urandom & 32'h00FF_FFFF));
                end
            end
        end
        @(posedge clk); #1;
        avail = 1'b0; allowed = 1'b1;
        repeat (30) @(posedge clk);
        check("drain_queue", exp_l.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
